// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: operating modes, control-word bit indices, default width.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned C_BITS    = 13;

  typedef enum logic [1:0] {
    MODE_ADDSUB = 2'd0,
    MODE_MUL    = 2'd1,
    MODE_DIV    = 2'd2
  } mode_e;

  // Bit positions inside the control word c[12:0]
  localparam int unsigned C_LD_ADD = 0;
  localparam int unsigned C_LD_MUL = 1;
  localparam int unsigned C_LD_DIV = 2;
  localparam int unsigned C_SHL    = 3;
  localparam int unsigned C_ADD    = 4;
  localparam int unsigned C_SUB    = 5;
  localparam int unsigned C_QBIT   = 6;
  localparam int unsigned C_ASR    = 7;
  localparam int unsigned C_CNT0   = 8;
  localparam int unsigned C_CNT1   = 9;
  localparam int unsigned C_CORR   = 10;
  localparam int unsigned C_OUT_A  = 11;
  localparam int unsigned C_OUT_Q  = 12;

endpackage

// File: rtl/alu_adder.sv
// Combinational add/subtract unit shared by the accumulate and remainder-correction paths.
module alu_adder #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum_c
);

  assign sum_c = sub ? (a - b) : (a + b);

endmodule

// File: rtl/alu_datapath.sv
// ALU register datapath: A/Q/M/Q-1/counter registers stepped by the control word,
// supporting add, subtract, Booth signed multiply and non-restoring unsigned divide.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [C_BITS-1:0]   c,
  input  logic [WIDTH-1:0]    x_in,
  input  logic [WIDTH-1:0]    y_in,
  output logic                q_0,
  output logic                q_min1,
  output logic                sign,
  output logic                cnt7,
  output logic [WIDTH-1:0]    outbus,
  output logic                out_valid
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] out_d;
  logic             vld_d;

  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    add_b;
  logic             add_sub;
  logic [AW-1:0]    sum_c;
  logic             shl_en;

  // Booth needs M sign-extended; add/sub and divide treat M as unsigned
  assign m_ext   = (mode_q == MODE_MUL) ? {{2{m_q[WIDTH-1]}}, m_q} : {2'b00, m_q};
  assign add_b   = c[C_CORR] ? {2'b00, m_q} : m_ext;
  assign add_sub = ~c[C_CORR] & c[C_SUB];
  assign shl_en  = c[C_SHL] && (mode_q == MODE_DIV);

  alu_adder #(.W(AW)) u_adder (
    .a     (a_q),
    .b     (add_b),
    .sub   (add_sub),
    .sum_c (sum_c)
  );

  // Next-state selection: loads win outright, then per-register priority chains
  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    qm1_d  = qm1_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    out_d  = outbus;
    vld_d  = c[C_OUT_A] | c[C_OUT_Q];

    if (c[C_LD_ADD]) begin
      a_d    = AW'(x_in);
      m_d    = y_in;
      q_d    = '0;
      qm1_d  = 1'b0;
      cnt_d  = '0;
      mode_d = MODE_ADDSUB;
    end else if (c[C_LD_MUL]) begin
      a_d    = '0;
      q_d    = x_in;
      m_d    = y_in;
      qm1_d  = 1'b0;
      cnt_d  = '0;
      mode_d = MODE_MUL;
    end else if (c[C_LD_DIV]) begin
      a_d    = '0;
      q_d    = x_in;
      m_d    = y_in;
      cnt_d  = '0;
      mode_d = MODE_DIV;
    end else begin
      if (c[C_CORR] || c[C_ADD]) begin
        a_d = sum_c;
      end else if (shl_en) begin
        a_d = {a_q[AW-2:0], q_q[WIDTH-1]};
      end else if (c[C_ASR]) begin
        a_d = {a_q[AW-1], a_q[AW-1:1]};
      end

      if (shl_en) begin
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end else if (c[C_ASR]) begin
        q_d   = {a_q[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
      end else if (c[C_QBIT]) begin
        q_d[0] = ~a_q[AW-1];
      end

      if (c[C_CNT0] || c[C_CNT1]) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (c[C_OUT_A]) begin
      out_d = a_q[WIDTH-1:0];
    end else if (c[C_OUT_Q]) begin
      out_d = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= MODE_ADDSUB;
      outbus    <= '0;
      out_valid <= 1'b0;
    end else begin
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      outbus    <= out_d;
      out_valid <= vld_d;
    end
  end

  // Status flags feed the control unit directly from register state
  assign q_0    = q_q[0];
  assign q_min1 = qm1_q;
  assign sign   = a_q[AW-1];
  assign cnt7   = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: operation-level arithmetic model feeds an expected-output queue,
// a per-cycle compare process checks outbus/out_valid, and literal checks pin the model.
module tb_alu_datapath;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  localparam logic [12:0] K_LD_ADD = 13'(1) << C_LD_ADD;
  localparam logic [12:0] K_LD_MUL = 13'(1) << C_LD_MUL;
  localparam logic [12:0] K_LD_DIV = 13'(1) << C_LD_DIV;
  localparam logic [12:0] K_SHL    = 13'(1) << C_SHL;
  localparam logic [12:0] K_ADD    = 13'(1) << C_ADD;
  localparam logic [12:0] K_SUB    = 13'(1) << C_SUB;
  localparam logic [12:0] K_QBIT   = 13'(1) << C_QBIT;
  localparam logic [12:0] K_ASR    = 13'(1) << C_ASR;
  localparam logic [12:0] K_CNT0   = 13'(1) << C_CNT0;
  localparam logic [12:0] K_CORR   = 13'(1) << C_CORR;
  localparam logic [12:0] K_OUT_A  = 13'(1) << C_OUT_A;
  localparam logic [12:0] K_OUT_Q  = 13'(1) << C_OUT_Q;

  logic         clk;
  logic         rst_n;
  logic [12:0]  c;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         q_0;
  logic         q_min1;
  logic         sign;
  logic         cnt7;
  logic [W-1:0] outbus;
  logic         out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_valid;

  alu_datapath #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c),
    .x_in      (x_in),
    .y_in      (y_in),
    .q_0       (q_0),
    .q_min1    (q_min1),
    .sign      (sign),
    .cnt7      (cnt7),
    .outbus    (outbus),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // An output step issued at an edge is expected on the bus after that edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_valid <= 1'b0;
    else        exp_valid <= c[C_OUT_A] | c[C_OUT_Q];
  end

  always @(negedge clk) begin
    n_chk++;
    if (out_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL out_valid: got %b, expected %b", out_valid, exp_valid);
    end
    if (exp_valid && rst_n) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL outbus_queue: got %h, expected no word", outbus);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (outbus !== e) begin
          n_fail++;
          $display("FAIL outbus: got %h, expected %h", outbus, e);
        end
      end
    end
  end

  task automatic cyc(input logic [12:0] cw);
    c = cw;
    @(posedge clk);
    #1;
  endtask

  task automatic do_addsub(input logic [W-1:0] x, input logic [W-1:0] y, input logic is_sub);
    logic [W-1:0] r;
    x_in = x;
    y_in = y;
    cyc(K_LD_ADD);
    cyc(is_sub ? (K_ADD | K_SUB) : K_ADD);
    chk("addsub_sign", 16'(sign), 16'(is_sub && (y > x)));
    r = is_sub ? W'(x - y) : W'(x + y);
    exp_q.push_back(r);
    cyc(K_OUT_A);
    cyc('0);
  endtask

  // Booth radix-2: decide on {Q0,Q-1}, then shift and count
  task automatic booth(input int iters);
    logic [12:0] cw;
    for (int i = 0; i < iters; i++) begin
      cw = '0;
      if (q_0 && !q_min1)      cw = K_ADD | K_SUB;
      else if (!q_0 && q_min1) cw = K_ADD;
      cyc(cw);
      cyc(K_ASR | K_CNT0);
      if (i == 5) chk("cnt7_after6", 16'(cnt7), 16'd0);
      if (i == 6) chk("cnt7_after7", 16'(cnt7), 16'd1);
    end
  endtask

  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] prod;
    x_in = x;
    y_in = y;
    prod = $signed(x) * $signed(y);
    cyc(K_LD_MUL);
    booth(W);
    exp_q.push_back(prod[2*W-1:W]);
    cyc(K_OUT_A);
    exp_q.push_back(prod[W-1:0]);
    cyc(K_OUT_Q);
    cyc('0);
  endtask

  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y);
    x_in = x;
    y_in = y;
    cyc(K_LD_DIV);
    for (int i = 0; i < int'(W); i++) begin
      cyc(K_SHL);
      cyc(sign ? K_ADD : (K_ADD | K_SUB));
      cyc(K_QBIT | K_CNT0);
    end
    if (sign) cyc(K_CORR);
    exp_q.push_back((y == 0) ? x : W'(x % y));
    cyc(K_OUT_A);
    exp_q.push_back((y == 0) ? {W{1'b1}} : W'(x / y));
    cyc(K_OUT_Q);
    cyc('0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_q0"},     16'(q_0),       16'd0);
    chk({tag, "_qm1"},    16'(q_min1),    16'd0);
    chk({tag, "_sign"},   16'(sign),      16'd0);
    chk({tag, "_cnt7"},   16'(cnt7),      16'd0);
    chk({tag, "_outbus"}, 16'(outbus),    16'd0);
    chk({tag, "_valid"},  16'(out_valid), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    c     = '0;
    x_in  = '0;
    y_in  = '0;
    @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    cyc('0);

    do_addsub(8'h25, 8'h13, 1'b0);
    chk("add_lit", 16'(outbus), 16'h0038);

    do_addsub(8'h10, 8'h20, 1'b1);
    chk("sub_lit", 16'(outbus), 16'h00F0);

    do_addsub(8'hFF, 8'h01, 1'b0);
    chk("add_wrap_lit", 16'(outbus), 16'h0000);

    do_mul(8'hFD, 8'h07);
    chk("mul_lo_lit", 16'(outbus), 16'h00EB);

    do_mul(8'h80, 8'h80);
    do_mul(8'h0C, 8'hF6);

    do_div(8'd100, 8'd7);
    chk("div_q_lit", 16'(outbus), 16'h000E);

    do_div(8'hFF, 8'hFE);
    do_div(8'h5A, 8'h00);
    chk("div0_q_lit", 16'(outbus), 16'h00FF);

    // Load beats accumulate; A-output beats Q-output
    x_in = 8'h33;
    y_in = 8'h11;
    cyc(K_LD_ADD | K_ADD);
    exp_q.push_back(8'h33);
    cyc(K_OUT_A | K_OUT_Q);
    chk("prio_lit", 16'(outbus), 16'h0033);
    cyc('0);

    // Reset between edges in the middle of a multiply
    x_in = 8'hFD;
    y_in = 8'h07;
    cyc(K_LD_MUL);
    booth(4);
    chk("pre_reset_outbus", 16'(outbus), 16'h0033);
    c = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    do_addsub(8'h25, 8'h13, 1'b0);
    chk("post_reset_add_lit", 16'(outbus), 16'h0038);
    cyc('0);

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
